// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the multi-port behavioural memory model.
// Queue entries carry read data, an out-of-range flag and an age counter.
package mem_model_pkg;

   localparam int MM_DATA_W      = 32;
   localparam int MM_DEPTH_WORDS = 4096;
   localparam int MM_QUEUE_DEPTH = 4;

   // Entries are sized for the widest supported word so one type serves every DATA_W up to 128.
   localparam int MM_MAX_DATA_W  = 128;
   localparam int MM_AGE_W       = 8;

   typedef struct packed {
      logic [MM_MAX_DATA_W-1:0] rdata;
      logic                     err;
      logic [MM_AGE_W-1:0]      age;
   } mm_entry_t;

   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int idx_width(input int depth_words);
      return $clog2(depth_words);
   endfunction

   function automatic int cnt_width(input int queue_depth);
      return $clog2(queue_depth + 1);
   endfunction

   function automatic logic [63:0] word_index(input logic [63:0] addr, input int lane_bits);
      return addr >> lane_bits;
   endfunction

endpackage

// File: rtl/mem_model_resp_queue.sv
// Per-port response FIFO: holds captured read data and error flags, ages each
// entry and presents the head once it has waited LATENCY edges.
module mem_model_resp_queue
   import mem_model_pkg::*;
#(
   parameter int DATA_W      = MM_DATA_W,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = MM_QUEUE_DEPTH
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic [DATA_W-1:0]                    push_rdata,
   input  logic                                 push_err,
   output logic                                 ready,
   output logic                                 res_valid,
   input  logic                                 res_ready,
   output logic [DATA_W-1:0]                    res_rdata,
   output logic                                 res_err,
   output logic [cnt_width(QUEUE_DEPTH)-1:0]    outstanding
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = cnt_width(QUEUE_DEPTH);

   mm_entry_t         entries [QUEUE_DEPTH];
   mm_entry_t         head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              pop;

   assign head        = entries[rd_ptr];
   assign res_valid   = (count != '0) && (head.age >= MM_AGE_W'(LATENCY));
   assign pop         = res_valid && res_ready;
   assign ready       = count < CNT_W'(QUEUE_DEPTH);
   assign res_rdata   = res_valid ? DATA_W'(head.rdata) : '0;
   assign res_err     = res_valid && head.err;
   assign outstanding = count;

   // Every slot ages each edge; a freshly written slot starts at 1, overriding its increment.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (entries[i].age < MM_AGE_W'(LATENCY)) begin
               entries[i].age <= entries[i].age + MM_AGE_W'(1);
            end
         end
         if (push) begin
            entries[wr_ptr] <= '{rdata: MM_MAX_DATA_W'(push_rdata), err: push_err, age: MM_AGE_W'(1)};
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/mem_model_mp.sv
// Multi-port behavioural memory: one shared word array behind NUM_PORTS
// independent request/response ports with latency, queueing and range errors.
module mem_model_mp
   import mem_model_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = MM_DATA_W,
   parameter int DEPTH_WORDS = MM_DEPTH_WORDS,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = MM_QUEUE_DEPTH
) (
   input  logic                                                i_clk,
   input  logic                                                i_reset,
   input  logic [NUM_PORTS-1:0]                                req_valid,
   output logic [NUM_PORTS-1:0]                                req_ready,
   input  logic [NUM_PORTS-1:0]                                req_we,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]                    req_addr,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]                    req_wdata,
   input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]                  req_wstrb,
   output logic [NUM_PORTS-1:0]                                res_valid,
   input  logic [NUM_PORTS-1:0]                                res_ready,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]                    res_rdata,
   output logic [NUM_PORTS-1:0]                                res_err,
   output logic [NUM_PORTS-1:0][cnt_width(QUEUE_DEPTH)-1:0]    outstanding
);

   localparam int LANES     = byte_lanes(DATA_W);
   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_W     = idx_width(DEPTH_WORDS);

   logic [DATA_W-1:0]                  mem [DEPTH_WORDS];
   logic [NUM_PORTS-1:0]               accept;
   logic [NUM_PORTS-1:0]               in_range;
   logic [NUM_PORTS-1:0][IDX_W-1:0]    word_idx;
   logic [NUM_PORTS-1:0][DATA_W-1:0]   push_rdata;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [63:0] wide_idx;

      assign wide_idx       = word_index(64'(req_addr[p]), LANE_BITS);
      assign in_range[p]    = wide_idx < 64'(DEPTH_WORDS);
      assign word_idx[p]    = wide_idx[IDX_W-1:0];
      assign accept[p]      = req_valid[p] && req_ready[p] && !i_reset;
      // Reads capture the array before this edge's writes land, so same-cycle readers see old data.
      assign push_rdata[p]  = (req_we[p] || !in_range[p]) ? '0 : mem[word_idx[p]];

      mem_model_resp_queue #(
         .DATA_W      (DATA_W),
         .LATENCY     (LATENCY),
         .QUEUE_DEPTH (QUEUE_DEPTH)
      ) u_queue (
         .clock       (i_clk),
         .reset       (i_reset),
         .push        (accept[p]),
         .push_rdata  (push_rdata[p]),
         .push_err    (!in_range[p]),
         .ready       (req_ready[p]),
         .res_valid   (res_valid[p]),
         .res_ready   (res_ready[p]),
         .res_rdata   (res_rdata[p]),
         .res_err     (res_err[p]),
         .outstanding (outstanding[p])
      );
   end

   // Ports are visited in ascending order, so the highest-numbered writer of a lane lands last and wins.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p] && req_we[p] && in_range[p]) begin
               for (int b = 0; b < LANES; b++) begin
                  if (req_wstrb[p][b]) begin
                     mem[word_idx[p]][b*8 +: 8] <= req_wdata[p][b*8 +: 8];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_model_mp.sv
// Self-checking bench for mem_model_mp: table-driven vectors plus hand-written
// sequences, with a per-port scoreboard checked as responses are consumed.
module tb_mem_model_mp;

   localparam int NP    = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4096;
   localparam int LAT   = 2;
   localparam int QD    = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NP-1:0]         req_valid, req_ready, req_we;
   logic [NP-1:0][AW-1:0] req_addr;
   logic [NP-1:0][DW-1:0] req_wdata;
   logic [NP-1:0][3:0]    req_wstrb;
   logic [NP-1:0]         res_valid, res_ready, res_err;
   logic [NP-1:0][DW-1:0] res_rdata;
   logic [NP-1:0][2:0]    outstanding;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      logic        exact;
   } exp_t;

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t mon_e;
   logic mon_empty;
   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   mem_model_mp #(
      .NUM_PORTS   (NP),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .QUEUE_DEPTH (QD)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_wstrb   (req_wstrb),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_rdata   (res_rdata),
      .res_err     (res_err),
      .outstanding (outstanding)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one request at a negedge and records what its response must be.
   task automatic applyStimulus(input int p, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] er, input logic ee, input logic exact);
      exp_t e;
      req_valid[p] = 1'b1;
      req_we[p]    = we;
      req_addr[p]  = addr;
      req_wdata[p] = wdata;
      req_wstrb[p] = wstrb;
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc;
      e.exact = exact;
      if (p == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 40 && (sb0.size() != 0 || sb1.size() != 0); i++) begin
         @(negedge clk);
      end
      total++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: pending responses p0=%0d p1=%0d, expected 0", sb0.size(), sb1.size());
      end
   endtask

   // Response checker: a response is consumed on the coming edge when valid and ready are both high.
   always begin
      @(negedge clk);
      #2;
      for (int p = 0; p < NP; p++) begin
         if (res_valid[p] && res_ready[p]) begin
            mon_empty = (p == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (mon_empty) begin
               total++;
               bad++;
               $display("[TB] FAIL spurious p%0d: res_valid=1 with nothing pending, expected 0", p);
            end else begin
               if (p == 0) mon_e = sb0.pop_front();
               else        mon_e = sb1.pop_front();
               checkOutput($sformatf("rdata p%0d", p), res_rdata[p], mon_e.rdata);
               checkOutput($sformatf("err p%0d", p), 32'(res_err[p]), 32'(mon_e.err));
               if (mon_e.exact)
                  checkOutput($sformatf("latency p%0d", p), 32'(cyc - mon_e.cyc), 32'(LAT));
               else
                  checkOutput($sformatf("min latency p%0d", p), 32'(cyc - mon_e.cyc >= LAT), 32'd1);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] bp_data [4];
      bp_data = '{32'h40404040, 32'h44444444, 32'h48484848, 32'h4C4C4C4C};

      vecs.push_back('{0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{0, 1'b1, 32'h20,   32'h0,        4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b1, 32'h40,   32'h40404040, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b1, 32'h44,   32'h44444444, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b1, 32'h48,   32'h48484848, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b1, 32'h4C,   32'h4C4C4C4C, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 32'h44,   32'h0,        4'h0, 32'h44444444, 1'b0});
      vecs.push_back('{1, 1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{0, 1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{0, 1'b1, 32'h0,    32'h0BADF00D, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{0, 1'b0, 32'h4000, 32'h0,        4'h0, 32'h0,        1'b1});
      vecs.push_back('{0, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{0, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0BADF00D, 1'b0});
      vecs.push_back('{1, 1'b1, 32'h50,   32'h0,        4'hF, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b1, 32'h50,   32'h12345678, 4'h5, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b0, 32'h50,   32'h0,        4'h0, 32'h00340078, 1'b0});
      vecs.push_back('{1, 1'b1, 32'h3FFC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1, 1'b0, 32'h3FFC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0});

      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      res_ready = '1;

      @(posedge clk);
      @(negedge clk);
      checkOutput("reset req_ready", 32'(req_ready), 32'h3);
      checkOutput("reset res_valid", 32'(res_valid), 32'h0);
      checkOutput("reset res_err", 32'(res_err), 32'h0);
      checkOutput("reset res_rdata", res_rdata[0] | res_rdata[1], 32'h0);
      checkOutput("reset outstanding", 32'(outstanding), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] table vectors");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                       vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
         step();
      end
      waitDrain();

      $display("[TB] same-cycle write/read and lane arbitration");
      applyStimulus(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
      step();
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11223344, 1'b0, 1'b1);
      step();
      applyStimulus(0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 32'h0, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 32'h20, 32'h55555555, 4'h3, 32'h0, 1'b0, 1'b1);
      step();
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hAAAA5555, 1'b0, 1'b1);
      step();
      waitDrain();

      $display("[TB] backpressure with full queue");
      res_ready[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, bp_data[i], 1'b0, 1'b0);
         step();
      end
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h50;
      checkOutput("full req_ready", 32'(req_ready[0]), 32'h0);
      checkOutput("full outstanding", 32'(outstanding[0]), 32'd4);
      step();
      checkOutput("held outstanding", 32'(outstanding[0]), 32'd4);
      for (int i = 0; i < 2; i++) begin
         checkOutput("held res_valid", 32'(res_valid[0]), 32'h1);
         checkOutput("held res_rdata", res_rdata[0], 32'h40404040);
         @(posedge clk);
         @(negedge clk);
      end
      res_ready[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("burst res_valid %0d", i), 32'(res_valid[0]), 32'h1);
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("burst done res_valid", 32'(res_valid[0]), 32'h0);
      checkOutput("burst done outstanding", 32'(outstanding[0]), 32'h0);
      waitDrain();

      $display("[TB] reset with entries in flight");
      res_ready[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, bp_data[i], 1'b0, 1'b0);
         step();
      end
      checkOutput("pre-reset outstanding", 32'(outstanding[0]), 32'd3);
      rst = 1'b1;
      sb0.delete();
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h10;
      req_wdata[1] = 32'h0;
      req_wstrb[1] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      checkOutput("post-reset outstanding", 32'(outstanding[0]), 32'h0);
      checkOutput("post-reset req_ready", 32'(req_ready[0]), 32'h1);
      checkOutput("post-reset res_valid", 32'(res_valid[0]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("discarded res_valid", 32'(res_valid[0]), 32'h0);
      res_ready[0] = 1'b1;
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      step();
      waitDrain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
